// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU select codes, control-FSM states.
// Also used by the ALU and register-file blocks.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_BRANCH    = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef struct packed {
    logic [2:0] alu_sel;
    logic       imm_sel;
    logic       neg_sel;
  } alu_ctl_t;

  function automatic logic is_alu_op(input logic [7:0] op);
    return op <= OP_OR;
  endfunction

  function automatic alu_ctl_t op_ctl(input logic [7:0] op);
    alu_ctl_t c;
    c = '0;
    unique case (1'b1)
      op == OP_LOADI: c.imm_sel = 1'b1;
      op == OP_ADD:   c.alu_sel = ALU_ADD;
      op == OP_SUB,
      op == OP_BEQ: begin
        c.alu_sel = ALU_ADD;
        c.neg_sel = 1'b1;
      end
      op == OP_AND:   c.alu_sel = ALU_AND;
      op == OP_OR:    c.alu_sel = ALU_OR;
      default:        c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with sequential (+4) and PC-relative branch next-PC.
// Offset is a signed word count relative to the following instruction.
module pc_unit #(
  parameter int unsigned         PC_W     = 32,
  parameter logic [PC_W-1:0]     PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            take_branch,
  input  logic [7:0]      offset,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] byte_off;

  assign seq_pc   = pc_q + PC_W'(4);
  assign byte_off = {{(PC_W-10){offset[7]}}, offset, 2'b00};

  always_comb begin
    pc_d = pc_q;
    if (advance) begin
      pc_d = take_branch ? seq_pc + byte_off : seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Drives ALU and register-file controls; resolves J/BEQ via ALU_ZERO.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RESET = '0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  output logic [PC_W-1:0] PC,
  output logic            INSTR_REQ,
  input  logic            INSTR_VALID,
  input  logic [31:0]     INSTRUCTION,
  output logic [2:0]      ALU_SELECT,
  input  logic            ALU_ZERO,
  output logic            IMM_SEL,
  output logic            NEG_SEL,
  output logic [7:0]      IMMEDIATE,
  output logic [2:0]      READREG1,
  output logic [2:0]      READREG2,
  output logic [2:0]      WRITEREG,
  output logic            WRITEENABLE,
  output logic            ILLEGAL
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        ill_q, ill_d;
  alu_ctl_t    ctl_q, ctl_d;

  logic [7:0]  op;
  logic        advance;
  logic        take_branch;
  logic [4:0]  unused_ir;

  assign op        = ir_q[31:24];
  assign unused_ir = ir_q[15:11];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    req_d   = 1'b0;
    we_d    = 1'b0;
    ill_d   = ill_q;
    ctl_d   = '0;
    unique case (state_q)
      ST_FETCH: begin
        if (req_q && INSTR_VALID) begin
          ir_d    = INSTRUCTION;
          state_d = ST_DECODE;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_DECODE: begin
        unique case (1'b1)
          is_alu_op(op) || op == OP_BEQ: begin
            state_d = ST_EXECUTE;
            ctl_d   = op_ctl(op);
          end
          op == OP_J: state_d = ST_BRANCH;
          default: begin
            state_d = ST_HALT;
            ill_d   = 1'b1;
          end
        endcase
      end
      ST_EXECUTE: begin
        ctl_d = ctl_q;
        if (op == OP_BEQ) begin
          state_d = ST_BRANCH;
        end else begin
          state_d = ST_WRITEBACK;
          we_d    = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
      ST_BRANCH: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
      ctl_q   <= ctl_d;
    end
  end

  // BEQ keeps ALU controls through BRANCH so ZERO stays valid when sampled
  assign advance     = state_q == ST_WRITEBACK
                    || state_q == ST_BRANCH;
  assign take_branch = state_q == ST_BRANCH
                    && (op == OP_J || ALU_ZERO);

  pc_unit #(
    .PC_W     (PC_W),
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .advance     (advance),
    .take_branch (take_branch),
    .offset      (ir_q[23:16]),
    .pc          (PC)
  );

  assign INSTR_REQ   = req_q;
  assign WRITEENABLE = we_q;
  assign ILLEGAL     = ill_q;
  assign ALU_SELECT  = ctl_q.alu_sel;
  assign IMM_SEL     = ctl_q.imm_sel;
  assign NEG_SEL     = ctl_q.neg_sel;
  assign IMMEDIATE   = ir_q[7:0];
  assign READREG1    = ir_q[10:8];
  assign READREG2    = ir_q[2:0];
  assign WRITEREG    = ir_q[18:16];

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: directed scenarios, then random programs
// checked per instruction against a transaction-level model.
module tb_cpu_control_fsm;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] PC;
  logic        INSTR_REQ;
  logic        INSTR_VALID = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic [2:0]  ALU_SELECT;
  logic        ALU_ZERO = 1'b0;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic [7:0]  IMMEDIATE;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [2:0]  WRITEREG;
  logic        WRITEENABLE;
  logic        ILLEGAL;

  always #5 CLK = ~CLK;

  cpu_control_fsm #(
    .PC_W     (32),
    .PC_RESET (32'h0)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .PC          (PC),
    .INSTR_REQ   (INSTR_REQ),
    .INSTR_VALID (INSTR_VALID),
    .INSTRUCTION (INSTRUCTION),
    .ALU_SELECT  (ALU_SELECT),
    .ALU_ZERO    (ALU_ZERO),
    .IMM_SEL     (IMM_SEL),
    .NEG_SEL     (NEG_SEL),
    .IMMEDIATE   (IMMEDIATE),
    .READREG1    (READREG1),
    .READREG2    (READREG2),
    .WRITEREG    (WRITEREG),
    .WRITEENABLE (WRITEENABLE),
    .ILLEGAL     (ILLEGAL)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] m_pc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_sel(input logic [7:0] op);
    case (op)
      8'h02, 8'h03, 8'h07: return 32'd1;
      8'h04:               return 32'd2;
      8'h05:               return 32'd3;
      default:             return 32'd0;
    endcase
  endfunction

  task automatic do_reset();
    RESET_N     = 1'b0;
    INSTR_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_pc",  PC, 32'h0);
    chk("rst_req", 32'(INSTR_REQ), 32'd0);
    chk("rst_we",  32'(WRITEENABLE), 32'd0);
    chk("rst_ill", 32'(ILLEGAL), 32'd0);
    chk("rst_sel", 32'(ALU_SELECT), 32'd0);
    chk("rst_imm", 32'(IMM_SEL), 32'd0);
    chk("rst_neg", 32'(NEG_SEL), 32'd0);
    RESET_N = 1'b1;
    m_pc    = 32'h0;
    @(negedge CLK);
    chk("c1_req", 32'(INSTR_REQ), 32'd1);
  endtask

  // Entered and left just after a negedge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins,
                           input int waits,
                           input bit zero,
                           output bit halted);
    logic [7:0]  op;
    logic [31:0] tgt;
    int          off;
    op       = ins[31:24];
    halted   = 1'b0;
    ALU_ZERO = zero;
    chk("f_req", 32'(INSTR_REQ), 32'd1);
    chk("f_pc",  PC, m_pc);
    for (int w = 0; w < waits; w++) begin
      INSTR_VALID = 1'b0;
      INSTRUCTION = $urandom;
      @(negedge CLK);
      chk("w_req", 32'(INSTR_REQ), 32'd1);
      chk("w_pc",  PC, m_pc);
      chk("w_we",  32'(WRITEENABLE), 32'd0);
    end
    INSTR_VALID = 1'b1;
    INSTRUCTION = ins;
    @(negedge CLK);
    INSTR_VALID = 1'($urandom_range(0, 1));
    INSTRUCTION = $urandom;
    chk("d_req", 32'(INSTR_REQ), 32'd0);
    chk("d_rr1", 32'(READREG1), 32'(ins[10:8]));
    chk("d_rr2", 32'(READREG2), 32'(ins[2:0]));
    chk("d_wr",  32'(WRITEREG), 32'(ins[18:16]));
    chk("d_imv", 32'(IMMEDIATE), 32'(ins[7:0]));
    chk("d_we",  32'(WRITEENABLE), 32'd0);
    chk("d_sel", 32'(ALU_SELECT), 32'd0);
    if (op > 8'h07) begin
      @(negedge CLK);
      chk("h_ill", 32'(ILLEGAL), 32'd1);
      chk("h_req", 32'(INSTR_REQ), 32'd0);
      INSTR_VALID = 1'b0;
      halted = 1'b1;
      return;
    end
    if (op != 8'h06) begin
      @(negedge CLK);
      chk("e_sel", 32'(ALU_SELECT), exp_sel(op));
      chk("e_imm", 32'(IMM_SEL), 32'(op == 8'h00));
      chk("e_neg", 32'(NEG_SEL), 32'(op == 8'h03 || op == 8'h07));
      chk("e_we",  32'(WRITEENABLE), 32'd0);
      chk("e_req", 32'(INSTR_REQ), 32'd0);
      if (op != 8'h07) begin
        @(negedge CLK);
        chk("wb_we",  32'(WRITEENABLE), 32'd1);
        chk("wb_sel", 32'(ALU_SELECT), exp_sel(op));
        chk("wb_imm", 32'(IMM_SEL), 32'(op == 8'h00));
        chk("wb_neg", 32'(NEG_SEL), 32'(op == 8'h03));
        chk("wb_wr",  32'(WRITEREG), 32'(ins[18:16]));
        chk("wb_pc",  PC, m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    if (op == 8'h06 || op == 8'h07) begin
      @(negedge CLK);
      chk("br_we", 32'(WRITEENABLE), 32'd0);
      chk("br_pc", PC, m_pc);
      off  = int'($signed(ins[23:16]));
      tgt  = m_pc + 32'd4 + 32'(off * 4);
      m_pc = (op == 8'h06 || zero) ? tgt : m_pc + 32'd4;
    end
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    chk("n_we",  32'(WRITEENABLE), 32'd0);
    chk("n_sel", 32'(ALU_SELECT), 32'd0);
    chk("n_ill", 32'(ILLEGAL), 32'd0);
    chk("n_pc",  PC, m_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          h;
    logic [31:0] r;
    logic [7:0]  op;
    do_reset();
    // LOADI r2,#5 with zero-wait memory
    run_instr({8'h00, 8'h02, 8'h00, 8'h05}, 0, 1'b0, h);
    // delayed INSTR_VALID
    run_instr({8'h02, 8'h01, 8'h02, 8'h03}, 3, 1'b0, h);
    run_instr({8'h00, 8'h04, 8'h00, 8'h11}, 0, 1'b0, h);
    run_instr({8'h01, 8'h05, 8'h04, 8'h00}, 1, 1'b0, h);
    chk("pc_10", PC, 32'h10);
    run_instr({8'h07, 8'hFE, 8'h01, 8'h02}, 0, 1'b1, h);
    chk("beq_t", PC, 32'h0C);
    run_instr({8'h02, 8'h00, 8'h01, 8'h02}, 0, 1'b0, h);
    run_instr({8'h07, 8'hFE, 8'h01, 8'h02}, 2, 1'b0, h);
    chk("beq_nt", PC, 32'h14);
    run_instr({8'h03, 8'h03, 8'h01, 8'h02}, 0, 1'b0, h);
    run_instr({8'h04, 8'h06, 8'h05, 8'h07}, 0, 1'b0, h);
    run_instr({8'h05, 8'h07, 8'h06, 8'h01}, 0, 1'b0, h);
    // PC wrap through zero
    do_reset();
    run_instr({8'h06, 8'hFE, 8'h00, 8'h00}, 0, 1'b0, h);
    chk("j_neg", PC, 32'hFFFF_FFFC);
    run_instr({8'h06, 8'h01, 8'h00, 8'h00}, 0, 1'b0, h);
    chk("j_wrap", PC, 32'h4);
    // illegal opcode halts
    run_instr({8'hFF, 8'h01, 8'h02, 8'h03}, 0, 1'b0, h);
    chk("ill_h", 32'(h), 32'd1);
    for (int i = 0; i < 20; i++) begin
      INSTR_VALID = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("hold_req", 32'(INSTR_REQ), 32'd0);
      chk("hold_ill", 32'(ILLEGAL), 32'd1);
      chk("hold_we",  32'(WRITEENABLE), 32'd0);
    end
    do_reset();
    // reset during WRITEBACK of ADD
    run_instr({8'h00, 8'h01, 8'h00, 8'h01}, 0, 1'b0, h);
    INSTR_VALID = 1'b1;
    INSTRUCTION = {8'h02, 8'h03, 8'h01, 8'h02};
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mr_we1", 32'(WRITEENABLE), 32'd1);
    #1 RESET_N = 1'b0;
    #1;
    chk("mr_we0", 32'(WRITEENABLE), 32'd0);
    chk("mr_pc",  PC, 32'h0);
    do_reset();
    // random programs
    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        op = 8'($urandom_range(8, 255));
      end else begin
        op = 8'($urandom_range(0, 7));
      end
      run_instr({op, r[23:0]}, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), h);
      if (h) begin
        repeat (3) @(negedge CLK);
        chk("r_hold", 32'(INSTR_REQ), 32'd0);
        do_reset();
      end
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
